// File: rtl/gf2_pkg.sv
// gf2_pkg
//  Shared types and helpers for the GF(2) solver blocks.
//  solve_state_t : FSM encoding of gf2_min_weight_solve.
//  popcount()    : number of set bits in a vector (up to FN_W bits, zero-extend narrower inputs).
//  parity()      : XOR reduction of a vector (up to FN_W bits).
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ANALYZE = 2'd1,
    ENUM    = 2'd2,
    DONE    = 2'd3
  } solve_state_t;

  localparam int FN_W = 32;

  function automatic int unsigned popcount(input logic [FN_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < FN_W; i++) begin
      c += {31'b0, v[i]};
    end
    return c;
  endfunction

  function automatic logic parity(input logic [FN_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/gf2_free_scatter.sv
// gf2_free_scatter
//  Combinational bit deposit (pdep): bit k of i_cnt is placed on the k-th set
//  bit of i_free_mask, scanning from var 0 upward. Positions outside the mask
//  are 0.
//  Ports:
//    i_free_mask [NVARS-1:0]  1 = free variable
//    i_cnt       [NVARS-1:0]  packed free-variable assignment
//    o_free_x    [NVARS-1:0]  assignment scattered to variable positions
module gf2_free_scatter #(
  parameter int NVARS = 3
) (
  input  logic [NVARS-1:0] i_free_mask,
  input  logic [NVARS-1:0] i_cnt,
  output logic [NVARS-1:0] o_free_x
);

  always_comb begin
    int k;
    k        = 0;
    o_free_x = '0;
    for (int j = 0; j < NVARS; j++) begin
      if (i_free_mask[j]) begin
        o_free_x[j] = i_cnt[k];
        k           = k + 1;
      end
    end
  end

endmodule

// File: rtl/gf2_min_weight_solve.sv
// gf2_min_weight_solve
//  Finds the minimum-weight solution x of A*x = b over GF(2), given the reduced
//  augmented matrix [A|b] from gf2_rref. Every assignment of the free
//  variables is tried, one candidate per cycle; the lightest consistent
//  candidate wins, ties going to the earliest candidate.
//  Handshake: start is a pulse sampled only in IDLE together with RREF; busy
//  is high while a run is in flight; done pulses for one cycle and the result
//  outputs are valid from then until the next done.
//  Ports:
//    clk, rst_n  clock, synchronous active-low reset
//    start       begin a run (ignored unless idle)
//    RREF        row r in RREF[r]; bit0 = b, bit (COLS-1-j) = coefficient of var j
//    busy        run in progress
//    done        one-cycle completion pulse
//    solvable    at least one consistent candidate found
//    min_weight  popcount of best solution, all-ones if unsolvable
//    solution    bit j = var j of best solution, 0 if unsolvable
//    o_state     current FSM state (debug)
module gf2_min_weight_solve
  import gf2_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ROWS-1:0][COLS-1:0]  RREF,
  output logic                       busy,
  output logic                       done,
  output logic                       solvable,
  output logic [$clog2(COLS):0]      min_weight,
  output logic [COLS-2:0]            solution,
  output solve_state_t               o_state
);

  localparam int NVARS = COLS - 1;
  localparam int MW    = $clog2(COLS) + 1;
  localparam int CW    = NVARS + 1;
  localparam int FW    = $clog2(NVARS + 1);

  solve_state_t               r_state;
  logic [ROWS-1:0][COLS-1:0]  r_mat;
  logic [NVARS-1:0]           r_piv_mask;
  logic [FW-1:0]              r_free_cnt;
  logic [CW-1:0]              r_cnt;
  logic [MW-1:0]              r_best_w;
  logic [NVARS-1:0]           r_best_x;
  logic                       r_found;

  // Row coefficients re-ordered so bit j is var j.
  logic [ROWS-1:0][NVARS-1:0] w_coef;
  logic [NVARS-1:0]           w_piv_mask;
  logic [NVARS-1:0]           w_free_x;
  logic [NVARS-1:0]           w_piv_val;
  logic [NVARS-1:0]           w_x;
  logic [ROWS-1:0]            w_row_ok;
  logic                       w_consistent;
  logic [MW-1:0]              w_wt;
  logic [CW-1:0]              w_cnt_last;

  genvar r, j;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      for (j = 0; j < NVARS; j++) begin : g_col
        assign w_coef[r][j] = r_mat[r][COLS-1-j];
      end
      assign w_row_ok[r] = (parity({{(FN_W-NVARS){1'b0}}, w_coef[r] & w_x}) == r_mat[r][0]);
    end

    for (j = 0; j < NVARS; j++) begin : g_var
      if (j < ROWS) begin : g_piv
        assign w_piv_mask[j] = r_mat[j][COLS-1-j];
        // Back-solve from the pivot row using only the free-variable part.
        assign w_piv_val[j]  = r_mat[j][0] ^
                               parity({{(FN_W-NVARS){1'b0}}, w_coef[j] & w_free_x});
      end else begin : g_nopiv
        assign w_piv_mask[j] = 1'b0;
        assign w_piv_val[j]  = 1'b0;
      end
      assign w_x[j] = r_piv_mask[j] ? w_piv_val[j] : w_free_x[j];
    end
  endgenerate

  gf2_free_scatter #(
    .NVARS (NVARS)
  ) u_scatter (
    .i_free_mask (~r_piv_mask),
    .i_cnt       (r_cnt[NVARS-1:0]),
    .o_free_x    (w_free_x)
  );

  assign w_consistent = &w_row_ok;
  assign w_wt         = MW'(popcount({{(FN_W-NVARS){1'b0}}, w_x}));
  assign w_cnt_last   = (CW'(1) << r_free_cnt) - CW'(1);
  assign o_state      = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mat      <= '0;
      r_piv_mask <= '0;
      r_free_cnt <= '0;
      r_cnt      <= '0;
      r_best_w   <= '1;
      r_best_x   <= '0;
      r_found    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      solvable   <= 1'b0;
      min_weight <= '1;
      solution   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mat   <= RREF;
            busy    <= 1'b1;
            r_state <= ANALYZE;
          end
        end
        ANALYZE: begin
          r_piv_mask <= w_piv_mask;
          r_free_cnt <= FW'(NVARS - int'(popcount({{(FN_W-NVARS){1'b0}}, w_piv_mask})));
          r_best_w   <= '1;
          r_best_x   <= '0;
          r_found    <= 1'b0;
          r_cnt      <= '0;
          r_state    <= ENUM;
        end
        ENUM: begin
          // Strict '<' keeps the earliest candidate on a weight tie.
          if (w_consistent && (w_wt < r_best_w)) begin
            r_best_w <= w_wt;
            r_best_x <= w_x;
            r_found  <= 1'b1;
          end
          if (r_cnt == w_cnt_last) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          done       <= 1'b1;
          solvable   <= r_found;
          min_weight <= r_best_w;
          solution   <= r_found ? r_best_x : '0;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
